// File: rtl/spi_master_bus.sv
// SPI master on the simple peripheral bus: DATA/STATUS/CTRL registers,
// programmable SCLK divider, all four SPI modes and software-driven chip selects.
module spi_master_bus #(
    parameter int NUM_CS      = 1,
    parameter int CLKDIV_W    = 8,
    parameter int DEFAULT_DIV = 49
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [31:0]       bus_addr,
    input  logic [31:0]       bus_wr_val,
    input  logic [3:0]        bus_bytesel,
    output logic              bus_ack,
    output logic [31:0]       bus_data,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic                cpol;
    logic                cpha;
    logic [NUM_CS-1:0]   cs_en;
    logic [CLKDIV_W-1:0] div;
    logic [CLKDIV_W-1:0] hcnt;
    logic [3:0]          edge_cnt;
    logic                busy;
    logic                rx_valid;
    logic                overrun;
    logic [7:0]          rx_data;
    logic [7:0]          tx_sr;
    logic [7:0]          rx_sr;

    logic        new_acc;
    logic        wr_acc;
    logic        rd_acc;
    logic [1:0]  reg_sel;
    logic [31:0] ctrl_val;
    logic [31:0] rd_val;
    logic        tick;
    logic        lead;
    logic        last;
    logic        unused;

    assign unused = ^{bus_addr[31:4], bus_addr[1:0], bus_wr_val};

    always_comb begin
        new_acc  = cs && !bus_ack;
        wr_acc   = new_acc && (bus_bytesel != 4'b0000);
        rd_acc   = new_acc && (bus_bytesel == 4'b0000);
        reg_sel  = bus_addr[3:2];
        ctrl_val = '0;
        ctrl_val[0] = cpol;
        ctrl_val[1] = cpha;
        ctrl_val[8+:NUM_CS]    = cs_en;
        ctrl_val[16+:CLKDIV_W] = div;
        case (reg_sel)
            2'd0:    rd_val = {24'b0, rx_data};
            2'd1:    rd_val = {29'b0, overrun, rx_valid, busy};
            2'd2:    rd_val = ctrl_val;
            default: rd_val = '0;
        endcase
        tick = (state == SHIFT) && (hcnt == div);
        lead = !edge_cnt[0];
        last = (edge_cnt == 4'd15);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus_ack  <= 1'b0;
            bus_data <= '0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b1;
            spi_cs_n <= '1;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            cs_en    <= '0;
            div      <= CLKDIV_W'(DEFAULT_DIV);
            hcnt     <= '0;
            edge_cnt <= '0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            rx_data  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            bus_ack  <= cs;
            bus_data <= (cs && bus_bytesel == 4'b0000) ? rd_val : '0;
            spi_cs_n <= ~cs_en;

            if (rd_acc && reg_sel == 2'd0) rx_valid <= 1'b0;
            if (rd_acc && reg_sel == 2'd1) overrun <= 1'b0;
            if (wr_acc && reg_sel == 2'd0 && busy) overrun <= 1'b1;

            // Mode and divider are frozen for the duration of a transfer
            if (wr_acc && reg_sel == 2'd2) begin
                cs_en <= bus_wr_val[8+:NUM_CS];
                if (!busy) begin
                    cpol <= bus_wr_val[0];
                    cpha <= bus_wr_val[1];
                    div  <= bus_wr_val[16+:CLKDIV_W];
                end
            end

            case (state)
                IDLE: begin
                    spi_sclk <= cpol;
                    if (wr_acc && reg_sel == 2'd0) begin
                        tx_sr    <= cpha ? bus_wr_val[7:0]
                                         : {bus_wr_val[6:0], 1'b0};
                        rx_sr    <= '0;
                        hcnt     <= '0;
                        edge_cnt <= '0;
                        busy     <= 1'b1;
                        rx_valid <= 1'b0;
                        state    <= SHIFT;
                        if (!cpha) spi_mosi <= bus_wr_val[7];
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        hcnt     <= '0;
                        spi_sclk <= ~spi_sclk;
                        edge_cnt <= edge_cnt + 4'd1;
                        // CPHA=0 samples on leading edges, CPHA=1 on trailing
                        if (lead == !cpha) begin
                            rx_sr <= {rx_sr[6:0], spi_miso};
                        end else if (!last) begin
                            spi_mosi <= tx_sr[7];
                            tx_sr    <= {tx_sr[6:0], 1'b0};
                        end
                        if (last) begin
                            rx_data  <= cpha ? {rx_sr[6:0], spi_miso} : rx_sr;
                            rx_valid <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        hcnt <= hcnt + CLKDIV_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_bus.sv
// Bench for spi_master_bus: elapsed-time transfer model compared every cycle,
// plus directed register accesses with literal expectations.
module tb_spi_master_bus;

    localparam int NCS = 1;
    localparam int DW  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cs = 1'b0;
    logic [31:0]    bus_addr = '0;
    logic [31:0]    bus_wr_val = '0;
    logic [3:0]     bus_bytesel = '0;
    logic           bus_ack;
    logic [31:0]    bus_data;
    logic           spi_sclk;
    logic           spi_mosi;
    logic           spi_miso;
    logic [NCS-1:0] spi_cs_n;

    logic       loop = 1'b1;
    logic [7:0] slave_byte = '0;
    logic       s_miso = 1'b1;
    logic       s_prev = 1'b0;
    logic [2:0] s_cnt = '0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign spi_miso = loop ? spi_mosi : s_miso;

    spi_master_bus #(.NUM_CS(NCS), .CLKDIV_W(DW), .DEFAULT_DIV(49)) dut (
        .clk(clk), .rst(rst), .cs(cs), .bus_addr(bus_addr),
        .bus_wr_val(bus_wr_val), .bus_bytesel(bus_bytesel),
        .bus_ack(bus_ack), .bus_data(bus_data), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    // Model state: a transfer is described by cycles elapsed since it started
    logic        m_ok = 1'b0;
    logic        m_ack, m_cpol, m_cpha, m_csen, m_busy, m_rxv, m_ovr;
    logic        m_sclk, m_mosi, m_csn;
    logic [31:0] m_data;
    logic [7:0]  m_div, m_rx, m_tx, m_rxexp;
    int          m_el;

    logic        n_ack, n_cpol, n_cpha, n_csen, n_busy, n_rxv, n_ovr;
    logic        n_sclk, n_mosi, n_csn;
    logic [31:0] n_data, rv;
    logic [7:0]  n_div, n_rx, n_tx, n_rxexp;
    int          n_el, n_k, n_idx;
    logic        a_new, a_wr, a_rd;
    logic [1:0]  a_sel;

    always_comb begin
        n_ack = cs; n_data = '0; n_cpol = m_cpol; n_cpha = m_cpha;
        n_csen = m_csen; n_div = m_div; n_busy = m_busy; n_rxv = m_rxv;
        n_ovr = m_ovr; n_rx = m_rx; n_tx = m_tx; n_rxexp = m_rxexp;
        n_el = m_el; n_k = 0; n_idx = -1; n_sclk = m_cpol;
        n_mosi = m_mosi; n_csn = ~m_csen; rv = '0;
        a_new = cs && !m_ack;
        a_wr = a_new && (bus_bytesel != 4'd0);
        a_rd = a_new && (bus_bytesel == 4'd0);
        a_sel = bus_addr[3:2];
        case (a_sel)
            2'd0: rv = {24'd0, m_rx};
            2'd1: rv = {29'd0, m_ovr, m_rxv, m_busy};
            2'd2: rv = {8'd0, m_div, 7'd0, m_csen, 6'd0, m_cpha, m_cpol};
            default: rv = '0;
        endcase
        if (cs && bus_bytesel == 4'd0) n_data = rv;
        if (a_rd && a_sel == 2'd0) n_rxv = 1'b0;
        if (a_rd && a_sel == 2'd1) n_ovr = 1'b0;
        if (a_wr && a_sel == 2'd2) begin
            n_csen = bus_wr_val[8];
            if (!m_busy) begin
                n_cpol = bus_wr_val[0];
                n_cpha = bus_wr_val[1];
                n_div  = bus_wr_val[23:16];
            end
        end
        if (m_busy) begin
            n_el = m_el + 1;
            n_k  = n_el / (int'(m_div) + 1);
            if (n_k >= 16) begin
                n_busy = 1'b0;
                n_rxv  = 1'b1;
                n_rx   = m_rxexp;
            end else begin
                n_sclk = m_cpol ^ n_k[0];
            end
            if (!m_cpha) n_idx = n_k / 2;
            else n_idx = (n_k + 1) / 2 - 1;
            if (n_idx > 7) n_idx = 7;
            if (n_idx >= 0) n_mosi = m_tx[7-n_idx];
        end
        if (a_wr && a_sel == 2'd0) begin
            if (m_busy) begin
                n_ovr = 1'b1;
            end else begin
                n_busy  = 1'b1;
                n_el    = 0;
                n_tx    = bus_wr_val[7:0];
                n_rxv   = 1'b0;
                n_rxexp = loop ? bus_wr_val[7:0] : slave_byte;
                n_sclk  = m_cpol;
                if (!m_cpha) n_mosi = bus_wr_val[7];
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ok <= 1'b1; m_ack <= 1'b0; m_data <= '0; m_cpol <= 1'b0;
            m_cpha <= 1'b0; m_csen <= 1'b0; m_div <= 8'd49; m_busy <= 1'b0;
            m_rxv <= 1'b0; m_ovr <= 1'b0; m_rx <= '0; m_tx <= '0;
            m_rxexp <= '0; m_el <= 0; m_sclk <= 1'b0; m_mosi <= 1'b1;
            m_csn <= 1'b1;
        end else begin
            m_ack <= n_ack; m_data <= n_data; m_cpol <= n_cpol;
            m_cpha <= n_cpha; m_csen <= n_csen; m_div <= n_div;
            m_busy <= n_busy; m_rxv <= n_rxv; m_ovr <= n_ovr; m_rx <= n_rx;
            m_tx <= n_tx; m_rxexp <= n_rxexp; m_el <= n_el;
            m_sclk <= n_sclk; m_mosi <= n_mosi; m_csn <= n_csn;
        end
    end

    // Slave: presents slave_byte MSB first, changing on each leading edge
    always @(negedge clk) begin
        s_prev <= spi_sclk;
        if (m_busy && spi_sclk != s_prev && spi_sclk != m_cpol) begin
            s_miso <= slave_byte[3'd7-s_cnt];
            s_cnt  <= s_cnt + 3'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("ack", 32'(bus_ack), 32'(m_ack));
                chk("bus_data", bus_data, m_data);
                chk("sclk", 32'(spi_sclk), 32'(m_sclk));
                chk("mosi", 32'(spi_mosi), 32'(m_mosi));
                chk("cs_n", 32'(spi_cs_n), 32'(m_csn));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] val);
        cs = 1'b1; bus_addr = 32'(addr); bus_wr_val = val; bus_bytesel = 4'hF;
        step();
        cs = 1'b0; bus_bytesel = 4'h0;
        step();
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp,
                      input string name);
        cs = 1'b1; bus_addr = 32'(addr); bus_bytesel = 4'h0;
        step();
        chk(name, bus_data, exp);
        cs = 1'b0;
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (dut.busy && n < 5000) begin
            n++;
            step();
        end
        chk("idle_timeout", 32'(dut.busy), 32'd0);
    endtask

    task automatic xfer(input logic [7:0] v, output int cyc, output int tog,
                        output int first, output logic [7:0] mbits);
        logic prev;
        cs = 1'b1; bus_addr = 32'd0; bus_wr_val = 32'(v); bus_bytesel = 4'hF;
        step();
        cs = 1'b0; bus_bytesel = 4'h0;
        cyc = 0; tog = 0; first = -1; mbits = '0; prev = spi_sclk;
        while (dut.busy && cyc < 5000) begin
            cyc++;
            step();
            if (spi_sclk != prev) begin
                tog++;
                if (first < 0) first = cyc;
                if (spi_sclk) mbits = {mbits[6:0], spi_mosi};
            end
            prev = spi_sclk;
        end
    endtask

    int         cyc, tog, first;
    logic [7:0] mb;

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd1);
        rd(4'h8, 32'h0031_0000, "ctrl_rst");
        rd(4'h4, 32'h0, "status_rst");
        rd(4'h0, 32'h0, "data_rst");

        wr(4'h8, 32'h0000_0100);
        loop = 1'b1;
        step();
        xfer(8'hA5, cyc, tog, first, mb);
        chk("m0_busy_cycles", 32'(cyc), 32'd16);
        chk("m0_toggles", 32'(tog), 32'd16);
        chk("m0_mosi_bits", 32'(mb), 32'hA5);
        rd(4'h4, 32'h2, "m0_status_rxv");
        rd(4'h0, 32'hA5, "m0_rx");
        rd(4'h4, 32'h0, "m0_status_clr");

        wr(4'h8, 32'h0003_0103);
        loop = 1'b0;
        slave_byte = 8'h3C;
        step();
        step();
        chk("m3_idle_sclk", 32'(spi_sclk), 32'd1);
        xfer(8'hFF, cyc, tog, first, mb);
        chk("m3_busy_cycles", 32'(cyc), 32'd64);
        chk("m3_half_period", 32'(first), 32'd4);
        chk("m3_toggles", 32'(tog), 32'd16);
        chk("m3_mosi_bits", 32'(mb), 32'hFF);
        chk("m3_end_sclk", 32'(spi_sclk), 32'd1);
        rd(4'h0, 32'h3C, "m3_rx");
        rd(4'h4, 32'h0, "m3_status");

        wr(4'h8, 32'h0001_0100);
        loop = 1'b1;
        step();
        wr(4'h0, 32'h5A);
        wr(4'h0, 32'h11);
        rd(4'h4, 32'h5, "ovr_status");
        rd(4'h4, 32'h1, "ovr_cleared");
        wr(4'h8, 32'h0005_0003);
        rd(4'h8, 32'h0001_0000, "ctrl_busy_write");
        wait_idle();
        rd(4'h4, 32'h2, "ovr_done_status");
        rd(4'h0, 32'h5A, "ovr_rx");
        rd(4'h4, 32'h0, "ovr_final");
        wr(4'h8, 32'h0001_0100);

        cs = 1'b1; bus_addr = 32'h0; bus_wr_val = 32'hC3; bus_bytesel = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_ack", 32'(bus_ack), 32'd1);
        end
        cs = 1'b0; bus_bytesel = 4'h0;
        step();
        chk("hold_ack_drop", 32'(bus_ack), 32'd0);
        wait_idle();
        rd(4'h4, 32'h2, "hold_single");
        rd(4'h0, 32'hC3, "hold_rx");

        wr(4'h0, 32'h96);
        repeat (13) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_sclk", 32'(spi_sclk), 32'd0);
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_busy", 32'(dut.busy), 32'd0);
        step();
        rd(4'h0, 32'h0, "abort_rx");
        rd(4'h4, 32'h0, "abort_status");
        rd(4'h8, 32'h0031_0000, "abort_ctrl");
        wr(4'h8, 32'h0001_0100);
        step();
        xfer(8'h3E, cyc, tog, first, mb);
        chk("post_busy_cycles", 32'(cyc), 32'd32);
        chk("post_mosi_bits", 32'(mb), 32'h3E);
        rd(4'h4, 32'h2, "post_status");
        rd(4'h0, 32'h3E, "post_rx");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
